adder_operand_capture: RTL and testbench

Input stage that sits directly upstream of the 2-bit full adder on the FPGA board. It synchronizes the raw slide-switch operands (A, B, carry-in) and a raw load pushbutton, debounces the button, and captures a coherent operand set on each confirmed press. It presents the captured set to the adder with a valid/ready handshake and flags presses lost to back-pressure.

---
 rtl/adder_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/adder_operand_capture.sv | 124 ++++++++++++
 tb/tb_adder_operand_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder operand input stage.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_e;

  // Debounce counter width; never below one bit so the counter always exists.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a group of asynchronous inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adder_operand_capture.sv
// Synchronizes switch operands and a load button, debounces the button and
// captures one operand set per confirmed press behind a valid/ready handshake.
module adder_operand_capture
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH           = ADDER_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_a,
  input  logic [WIDTH-1:0] sw_b,
  input  logic             sw_cin,
  input  logic             btn_load,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             overrun
);

  localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2*WIDTH:0] sw_s;
  logic             btn_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             cin_s;

  btn_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             press_confirmed;

  sync_2ff #(.WIDTH(2*WIDTH+1)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({sw_a, sw_b, sw_cin}),
    .q     (sw_s)
  );

  sync_2ff #(.WIDTH(1)) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_load),
    .q     (btn_s)
  );

  assign a_s   = sw_s[2*WIDTH -: WIDTH];
  assign b_s   = sw_s[WIDTH -: WIDTH];
  assign cin_s = sw_s[0];

  always_comb begin
    press_confirmed = 1'b0;
    if (state == PRESS_WAIT && btn_s && cnt == CNT_LAST)
      press_confirmed = 1'b1;
  end

  // Counter only runs in the two qualifying states; any level mismatch or
  // state change returns it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_s) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          cnt <= '0;
          if (!btn_s) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (press_confirmed && (!op_valid || op_ready)) begin
      op_a     <= a_s;
      op_b     <= b_s;
      op_cin   <= cin_s;
      op_valid <= 1'b1;
    end else begin
      if (op_valid && op_ready) op_valid <= 1'b0;
      if (press_confirmed)      overrun  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_operand_capture.sv
// Self-checking bench for adder_operand_capture with a short debounce window.
module tb_adder_operand_capture;

  localparam int unsigned DEB = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw_a, sw_b;
  logic       sw_cin;
  logic       btn_load;
  logic [1:0] op_a, op_b;
  logic       op_cin, op_valid, op_ready, overrun;

  logic [3:0] sw_a4, sw_b4;
  logic       sw_cin4;
  logic [3:0] op_a4, op_b4;
  logic       op_cin4, op_valid4, overrun4;

  int unsigned total;
  int unsigned bad;

  adder_operand_capture #(.WIDTH(2), .DEBOUNCE_CYCLES(DEB)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_b(sw_b), .sw_cin(sw_cin),
    .btn_load(btn_load), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .op_valid(op_valid), .op_ready(op_ready), .overrun(overrun)
  );

  adder_operand_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sw_a(sw_a4), .sw_b(sw_b4), .sw_cin(sw_cin4),
    .btn_load(btn_load), .op_a(op_a4), .op_b(op_b4), .op_cin(op_cin4),
    .op_valid(op_valid4), .op_ready(op_ready), .overrun(overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a press is the synchronized button differing from the
  // debounced level for DEB+1 consecutive samples.
  logic        q_btn0, q_btn1;
  logic [1:0]  qa0, qa1, qb0, qb1;
  logic        qc0, qc1;
  logic        m_level;
  int unsigned m_run;
  logic [1:0]  m_a, m_b;
  logic        m_cin, m_valid, m_ovr;

  task automatic model_reset();
    q_btn0 = 1'b0; q_btn1 = 1'b0;
    qa0 = '0; qa1 = '0; qb0 = '0; qb1 = '0; qc0 = 1'b0; qc1 = 1'b0;
    m_level = 1'b0; m_run = 0;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_edge();
    logic press;
    if (!rst_n) begin
      model_reset();
      return;
    end
    press = 1'b0;
    if (q_btn1 != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = q_btn1;
        m_run   = 0;
        press   = q_btn1;
      end
    end else begin
      m_run = 0;
    end
    if (press && (!m_valid || op_ready)) begin
      m_a = qa1; m_b = qb1; m_cin = qc1; m_valid = 1'b1;
    end else begin
      if (m_valid && op_ready) m_valid = 1'b0;
      if (press) m_ovr = 1'b1;
    end
    q_btn1 = q_btn0; q_btn0 = btn_load;
    qa1 = qa0; qa0 = sw_a;
    qb1 = qb0; qb0 = sw_b;
    qc1 = qc0; qc0 = sw_cin;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({op_a, op_b, op_cin, op_valid, overrun});
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model", outs(), 32'({m_a, m_b, m_cin, m_valid, m_ovr}));
  endtask

  task automatic set_sw(input logic [1:0] a, input logic [1:0] b, input logic c);
    sw_a = a; sw_b = b; sw_cin = c;
  endtask

  task automatic press_hold(input int unsigned hold, output int unsigned first_edge,
                            output int unsigned n_valid);
    first_edge = 0;
    n_valid    = 0;
    btn_load   = 1'b1;
    for (int unsigned i = 1; i <= hold; i++) begin
      step();
      if (op_valid) begin
        n_valid++;
        if (first_edge == 0) first_edge = i;
      end
    end
  endtask

  task automatic release_btn(input int unsigned n);
    btn_load = 1'b0;
    repeat (n) step();
  endtask

  typedef struct {
    logic [1:0] a, b;
    logic       cin;
    logic [1:0] ea, eb;
    logic       ecin;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned fe, nv, cnt;
    total = 0; bad = 0;
    rst_n = 1'b0; btn_load = 1'b0; op_ready = 1'b1;
    set_sw(2'd0, 2'd0, 1'b0);
    sw_a4 = '0; sw_b4 = '0; sw_cin4 = 1'b0;
    model_reset();

    vecs[0] = '{a: 2'b10, b: 2'b11, cin: 1'b1, ea: 2'd2, eb: 2'd3, ecin: 1'b1};
    vecs[1] = '{a: 2'b11, b: 2'b11, cin: 1'b1, ea: 2'd3, eb: 2'd3, ecin: 1'b1};
    vecs[2] = '{a: 2'b00, b: 2'b00, cin: 1'b0, ea: 2'd0, eb: 2'd0, ecin: 1'b0};
    vecs[3] = '{a: 2'b01, b: 2'b10, cin: 1'b0, ea: 2'd1, eb: 2'd2, ecin: 1'b0};

    repeat (3) step();
    check("reset_state", outs(), 32'd0);
    rst_n = 1'b1;

    // Clean presses, table driven; WIDTH=4 instance captures all-ones A.
    for (int unsigned i = 0; i < 4; i++) begin
      set_sw(vecs[i].a, vecs[i].b, vecs[i].cin);
      sw_a4 = 4'hF; sw_b4 = 4'h0; sw_cin4 = 1'b0;
      press_hold(20, fe, nv);
      check("clean_latency", fe, 7);
      check("clean_single", nv, 1);
      check("clean_data", 32'({op_a, op_b, op_cin}),
            32'({vecs[i].ea, vecs[i].eb, vecs[i].ecin}));
      check("w4_data", 32'(op_a4), 32'hF);
      set_sw(~vecs[i].a, ~vecs[i].b, ~vecs[i].cin);
      release_btn(20);
      check("clean_hold_data", 32'({op_a, op_b, op_cin}),
            32'({vecs[i].ea, vecs[i].eb, vecs[i].ecin}));
    end

    // Bounce on press, then bounce on release.
    set_sw(2'd1, 2'd1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      btn_load = (i % 2 == 0);
      step();
    end
    press_hold(20, fe, nv);
    check("bounce_latency", fe, 7);
    check("bounce_single", nv, 1);
    cnt = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      btn_load = (i % 2 == 1);
      step();
      if (op_valid) cnt++;
    end
    btn_load = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      if (op_valid) cnt++;
    end
    check("release_bounce_none", cnt, 0);

    // Capture coinciding with acceptance of the previous set.
    op_ready = 1'b0;
    set_sw(2'd2, 2'd1, 1'b1);
    press_hold(20, fe, nv);
    check("simul_first", fe, 7);
    release_btn(20);
    set_sw(2'd1, 2'd3, 1'b0);
    btn_load = 1'b1;
    repeat (6) step();
    op_ready = 1'b1;
    step();
    check("simul_valid_data", 32'({op_a, op_b, op_cin, op_valid, overrun}),
          32'({2'd1, 2'd3, 1'b0, 1'b1, 1'b0}));
    step();
    check("simul_drop", 32'(op_valid), 32'd0);
    release_btn(20);

    // Back-pressure and overrun.
    op_ready = 1'b0;
    set_sw(2'd3, 2'd0, 1'b1);
    press_hold(20, fe, nv);
    check("bp_latency", fe, 7);
    check("bp_valid_held", nv, 14);
    set_sw(2'd0, 2'd3, 1'b0);
    release_btn(20);
    check("bp_data_held", 32'({op_a, op_b, op_cin, op_valid}), 32'({2'd3, 2'd0, 1'b1, 1'b1}));
    press_hold(20, fe, nv);
    check("bp_overrun", 32'({op_a, op_b, op_cin, op_valid, overrun}),
          32'({2'd3, 2'd0, 1'b1, 1'b1, 1'b1}));
    op_ready = 1'b1;
    step();
    check("bp_accept", 32'({op_valid, overrun}), 32'({1'b0, 1'b1}));
    release_btn(20);

    // Reset during PRESS_WAIT with count=2.
    btn_load = 1'b1;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1 check("rst_pw_async", outs(), 32'd0);
    model_reset();
    btn_load = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    set_sw(2'd3, 2'd3, 1'b1);
    press_hold(20, fe, nv);
    check("rst_pw_relatency", fe, 7);
    release_btn(20);

    // Reset while a set is pending.
    op_ready = 1'b0;
    set_sw(2'd2, 2'd2, 1'b0);
    press_hold(20, fe, nv);
    check("rst_hs_pending", 32'(op_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_hs_async", outs(), 32'd0);
    model_reset();
    btn_load = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    press_hold(20, fe, nv);
    check("rst_hs_relatency", fe, 7);
    release_btn(20);
    op_ready = 1'b1;
    step();

    // Random bursts against the reference model.
    for (int unsigned burst = 0; burst < 300; burst++) begin
      logic lvl;
      int unsigned len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int unsigned k = 0; k < len; k++) begin
        set_sw(2'($urandom), 2'($urandom), 1'($urandom));
        op_ready = ($urandom_range(0, 3) != 0);
        btn_load = lvl;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
